reg_wr_sched: RTL and testbench

Round-robin write scheduler that shares the single `WIDTH`-bit register datapath between `NUM_REQ` requesters. The block arbitrates write requests and drives the register's `enable`/`data` inputs for exactly one cycle per granted write. It then reads the register's `outa` back, checks that it matches the written value, and returns a per-requester acknowledge with an error flag. It sits between the stimulus/requester agents and the register, and replaces direct drive of the register's `enable`/`data`.

---
 rtl/reg_arb_pkg.sv | 8 +
 rtl/rr_pick.sv | 32 +++
 rtl/reg_wr_sched.sv | 119 +++++++++++
 tb/tb_reg_wr_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register write scheduler.
package reg_arb_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, VERIFY} sched_state_t;

  localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first asserted request at or after ptr wins,
// and the search wraps modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         win_oh,
  output logic [$clog2(NUM_REQ)-1:0] win_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic             found;
  logic [IDX_W-1:0] cidx;

  always_comb begin
    found   = 1'b0;
    cidx    = '0;
    win_oh  = '0;
    win_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cidx = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[cidx]) begin
        found         = 1'b1;
        win_oh[cidx]  = 1'b1;
        win_idx       = cidx;
      end
    end
  end

endmodule

// File: rtl/reg_wr_sched.sv
// Round-robin write scheduler: grants one requester, writes the shared register for
// one cycle, reads it back and returns a one-cycle ack with a mismatch flag.
module reg_wr_sched
  import reg_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     ack_err,
  output logic [ERR_CNT_W-1:0]     err_cnt,
  output logic                     busy,
  output logic                     reg_enable,
  output logic [WIDTH-1:0]         reg_data,
  input  logic [WIDTH-1:0]         reg_outa
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  sched_state_t       state, next_state;
  logic [IDX_W-1:0]   ptr, win_idx;
  logic [WIDTH-1:0]   win_data;
  logic [NUM_REQ-1:0] pick_oh, win_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic [WIDTH-1:0]   sel_data;
  logic               any_req, mismatch;

  logic [NUM_REQ-1:0] gnt_d, ack_d;
  logic               ack_err_d, busy_d, reg_enable_d;
  logic [WIDTH-1:0]   reg_data_d;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  assign any_req  = |req;
  assign sel_data = req_data[pick_idx*WIDTH +: WIDTH];
  assign mismatch = (reg_outa != win_data);
  assign win_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = WRITE;
      WRITE:   next_state = VERIFY;
      VERIFY:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs; every output leaves a flop.
  always_comb begin
    gnt_d        = '0;
    ack_d        = '0;
    ack_err_d    = 1'b0;
    reg_enable_d = 1'b0;
    reg_data_d   = reg_data;
    busy_d       = (next_state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_d        = pick_oh;
          reg_enable_d = 1'b1;
          reg_data_d   = sel_data;
        end
      end
      WRITE:  gnt_d = gnt;
      VERIFY: begin
        ack_d     = win_oh;
        ack_err_d = mismatch;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt        <= '0;
      ack        <= '0;
      ack_err    <= 1'b0;
      busy       <= 1'b0;
      reg_enable <= 1'b0;
      reg_data   <= '0;
      err_cnt    <= '0;
      ptr        <= '0;
      win_idx    <= '0;
      win_data   <= '0;
    end else begin
      gnt        <= gnt_d;
      ack        <= ack_d;
      ack_err    <= ack_err_d;
      busy       <= busy_d;
      reg_enable <= reg_enable_d;
      reg_data   <= reg_data_d;
      if (state == IDLE && any_req) begin
        win_idx  <= pick_idx;
        win_data <= sel_data;
      end
      if (state == VERIFY) begin
        ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        if (mismatch && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_wr_sched.sv
// Scoreboard bench for reg_wr_sched with a behavioural register model (optionally stuck at 0).
module tb_reg_wr_sched;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned NUM_REQ = 4;

  logic                     clk, reset_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       gnt, ack;
  logic                     ack_err, busy, reg_enable;
  logic [7:0]               err_cnt;
  logic [WIDTH-1:0]         reg_data, reg_outa, reg_q;
  logic                     stuck;

  int checks   = 0;
  int failures = 0;

  typedef struct { int unsigned idx; logic [7:0] data; } wr_t;
  typedef struct { int unsigned idx; logic err; } ack_t;
  wr_t  exp_wr[$];
  ack_t exp_ack[$];
  wr_t  mw;
  ack_t ma;
  logic [3:0] mg;

  reg_wr_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
    .gnt(gnt), .ack(ack), .ack_err(ack_err), .err_cnt(err_cnt), .busy(busy),
    .reg_enable(reg_enable), .reg_data(reg_data), .reg_outa(reg_outa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        reg_q <= '0;
    else if (reg_enable) reg_q <= reg_data;
  end
  assign reg_outa = stuck ? 8'h00 : reg_q;

  // Scoreboard monitor: every register write and every ack must match the queue front.
  always @(negedge clk) begin
    if (reg_enable === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: reg_data=%h gnt=%b, expected no write", reg_data, gnt);
      end else begin
        mw = exp_wr.pop_front();
        mg = 4'b0001 << mw.idx;
        if (reg_data !== mw.data || gnt !== mg) begin
          failures++;
          $display("FAIL wr_match: reg_data=%h gnt=%b, expected reg_data=%h gnt=%b",
                   reg_data, gnt, mw.data, mg);
        end
      end
    end
    if (ack !== 4'b0000) begin
      checks++;
      if (exp_ack.size() == 0) begin
        failures++;
        $display("FAIL ack_unexpected: ack=%b ack_err=%b, expected no ack", ack, ack_err);
      end else begin
        ma = exp_ack.pop_front();
        mg = 4'b0001 << ma.idx;
        if (ack !== mg || ack_err !== ma.err) begin
          failures++;
          $display("FAIL ack_match: ack=%b ack_err=%b, expected ack=%b ack_err=%b",
                   ack, ack_err, mg, ma.err);
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0; req = '0; req_data = '0; stuck = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, ack, ack_err, busy, reg_enable} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: gnt=%b ack=%b ack_err=%b busy=%b en=%b, expected all 0",
               gnt, ack, ack_err, busy, reg_enable);
    end
    checks++;
    if (err_cnt !== 8'd0 || reg_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_data: err_cnt=%0d reg_data=%h, expected 0 and 00", err_cnt, reg_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_single();
    req_data[7:0] = 8'hA5; req = 4'b0001;
    exp_wr.push_back('{0, 8'hA5}); exp_ack.push_back('{0, 1'b0});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (reg_enable !== 1'b1 || busy !== 1'b1 || reg_data !== 8'hA5) begin
          failures++;
          $display("FAIL single_write: en=%b busy=%b data=%h, expected 1 1 a5", reg_enable, busy, reg_data);
        end
      end else if (k == 2) begin
        checks++;
        if (reg_enable !== 1'b0 || busy !== 1'b1 || gnt !== 4'b0001) begin
          failures++;
          $display("FAIL single_verify: en=%b busy=%b gnt=%b, expected 0 1 0001", reg_enable, busy, gnt);
        end
      end else begin
        checks++;
        if (ack !== 4'b0001 || ack_err !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin
          failures++;
          $display("FAIL single_ack: ack=%b err=%b busy=%b gnt=%b, expected 0001 0 0 0000",
                   ack, ack_err, busy, gnt);
        end
        req = '0;
      end
    end
    @(negedge clk);
    checks++;
    if (err_cnt !== 8'd0 || ack !== 4'b0000) begin
      failures++;
      $display("FAIL single_after: err_cnt=%0d ack=%b, expected 0 0000", err_cnt, ack);
    end
  endtask

  task automatic test_rotation();
    #2 reset_n = 1'b0;
    req = 4'b1111; req_data = 32'h44332211;
    repeat (2) @(negedge clk);
    exp_wr.push_back('{0, 8'h11}); exp_wr.push_back('{1, 8'h22});
    exp_wr.push_back('{2, 8'h33}); exp_wr.push_back('{3, 8'h44});
    exp_wr.push_back('{0, 8'h11});
    for (int unsigned i = 0; i < 4; i++) exp_ack.push_back('{i, 1'b0});
    exp_ack.push_back('{0, 1'b0});
    reset_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++;
      if (reg_enable !== (k % 3 == 1)) begin
        failures++;
        $display("FAIL rotation_spacing: cycle %0d en=%b, expected %b", k, reg_enable, (k % 3 == 1));
      end
      if (k == 15) req = '0;
    end
  endtask

  task automatic test_error();
    stuck = 1'b1;
    req_data[23:16] = 8'h3C; req = 4'b0100;
    for (int i = 0; i < 300; i++) begin
      exp_wr.push_back('{2, 8'h3C});
      exp_ack.push_back('{2, 1'b1});
    end
    for (int k = 1; k <= 900; k++) begin
      @(negedge clk);
      if (k == 3) begin
        checks++;
        if (ack !== 4'b0100 || ack_err !== 1'b1 || err_cnt !== 8'd1) begin
          failures++;
          $display("FAIL error_first: ack=%b err=%b err_cnt=%0d, expected 0100 1 1", ack, ack_err, err_cnt);
        end
      end
      if (k == 900) begin
        checks++;
        if (err_cnt !== 8'd255) begin
          failures++;
          $display("FAIL error_saturate: err_cnt=%0d, expected 255", err_cnt);
        end
        req = '0;
      end
    end
    @(negedge clk);
    checks++;
    if (err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL error_hold: err_cnt=%0d, expected 255", err_cnt);
    end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_data[15:8] = 8'h77; req = 4'b0010;
    exp_wr.push_back('{1, 8'h77});
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL mid_grant: gnt=%b, expected 0010", gnt);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (reg_enable !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: en=%b gnt=%b busy=%b, expected 0 0000 0", reg_enable, gnt, busy);
    end
    req = 4'b1111; req_data = 32'h44332211;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (ack !== 4'b0000) begin
        failures++;
        $display("FAIL mid_no_ack: ack=%b, expected 0000", ack);
      end
    end
    exp_wr.push_back('{0, 8'h11}); exp_ack.push_back('{0, 1'b0});
    reset_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (gnt !== 4'b0001) begin
          failures++;
          $display("FAIL mid_first_grant: gnt=%b, expected 0001", gnt);
        end
      end
      if (k == 3) req = '0;
    end
  endtask

  task automatic test_data_change();
    req_data[31:24] = 8'h5A; req = 4'b1000;
    exp_wr.push_back('{3, 8'h5A}); exp_ack.push_back('{3, 1'b0});
    exp_wr.push_back('{3, 8'hFF}); exp_ack.push_back('{3, 1'b0});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 2) req_data[31:24] = 8'hFF;
      if (k == 3) begin
        checks++;
        if (ack !== 4'b1000 || ack_err !== 1'b0) begin
          failures++;
          $display("FAIL change_ack: ack=%b err=%b, expected 1000 0", ack, ack_err);
        end
      end
      if (k == 4) begin
        checks++;
        if (reg_enable !== 1'b1 || reg_data !== 8'hFF) begin
          failures++;
          $display("FAIL change_next: en=%b data=%h, expected 1 ff", reg_enable, reg_data);
        end
      end
      if (k == 6) req = '0;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_error();
    test_reset_mid();
    test_data_change();
    checks++;
    if (exp_wr.size() != 0 || exp_ack.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: writes left=%0d acks left=%0d, expected 0 0",
               exp_wr.size(), exp_ack.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
